// File: rtl/ac_motor_carrier_gen_if.sv
// ac_motor_carrier_gen_if
//   Control and carrier bundle of the AC motor carrier generator.
//   master : control loop side, which drives ENABLE/MODE/STEP and receives the carriers.
//   slave  : generator side.
//   ENABLE  run carrier (low = idle)
//   MODE    0 = triangle, 1 = sawtooth
//   STEP    unsigned level increment per clock
//   CARRIER packed signed carriers, channel k at [k*OUTPUT_BITS +: OUTPUT_BITS]
//   PEAK    pulse with LMAX on CARRIER (triangle only)
//   VALLEY  pulse with LMIN on CARRIER
//   LOCK    carrier running and phase-aligned
interface ac_motor_carrier_gen_if #(
    parameter int unsigned OUTPUT_BITS = 24,
    parameter int unsigned LEVEL_BITS  = 13,
    parameter int unsigned CHANNELS    = 3
);
    logic                              ENABLE;
    logic                              MODE;
    logic [LEVEL_BITS-2:0]             STEP;
    logic [CHANNELS*OUTPUT_BITS-1:0]   CARRIER;
    logic                              PEAK;
    logic                              VALLEY;
    logic                              LOCK;

    modport master (
        output ENABLE, MODE, STEP,
        input  CARRIER, PEAK, VALLEY, LOCK
    );

    modport slave (
        input  ENABLE, MODE, STEP,
        output CARRIER, PEAK, VALLEY, LOCK
    );
endinterface

// File: rtl/ac_motor_carrier_gen.sv
// ac_motor_carrier_gen
//   Multi-channel PWM carrier generator. One shared signed level counter runs a
//   triangle or sawtooth between LMIN and LMAX with a runtime step size; step and
//   mode are shadowed and only take effect at the carrier valley. Each channel is
//   the scaled level, optionally negated for interleaved legs.
//   CLK    rising-edge system clock
//   RST_N  asynchronous active-low reset
//   cbus   slave side of ac_motor_carrier_gen_if (ENABLE/MODE/STEP in,
//          CARRIER/PEAK/VALLEY/LOCK out)
module ac_motor_carrier_gen #(
    parameter int unsigned         OUTPUT_BITS = 24,
    parameter int unsigned         LEVEL_BITS  = 13,
    parameter int unsigned         CHANNELS    = 3,
    parameter logic [CHANNELS-1:0] PHASE_INV   = '0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    ac_motor_carrier_gen_if.slave cbus
);

    localparam int unsigned W = LEVEL_BITS + 1;
    localparam logic signed [W-1:0] LMAX_W = W'((1 << (LEVEL_BITS - 1)) - 1);
    localparam logic signed [W-1:0] LMIN_W = -LMAX_W;

    typedef enum logic { DIR_UP, DIR_DOWN } dir_e;
    typedef enum logic { MODE_TRI, MODE_SAW } mode_e;

    // Counter stage
    logic signed [LEVEL_BITS-1:0] cnt_q, cnt_d;
    dir_e                         dir_q, dir_d;
    logic [LEVEL_BITS-2:0]        step_sh_q, step_sh_d;
    mode_e                        mode_sh_q, mode_sh_d;
    logic                         peak_f_q, peak_f_d;
    logic                         valley_f_q, valley_f_d;

    // Output stage
    logic [CHANNELS*OUTPUT_BITS-1:0] carrier_q, carrier_d;
    logic                            peak_q, valley_q, lock_q;

    logic [LEVEL_BITS-2:0]        step_eff;
    logic signed [W-1:0]          cnt_ext, step_ext, sum, diff;
    logic signed [LEVEL_BITS-1:0] lvl_k;
    logic signed [OUTPUT_BITS-1:0] ext_k;

    assign step_eff = (step_sh_q == '0) ? (LEVEL_BITS-1)'(1) : step_sh_q;
    assign cnt_ext  = {cnt_q[LEVEL_BITS-1], cnt_q};
    assign step_ext = {2'b00, step_eff};
    // One guard bit keeps cnt +/- step exact, so the clamp compares never see a wrap.
    assign sum      = cnt_ext + step_ext;
    assign diff     = cnt_ext - step_ext;

    always_comb begin
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        step_sh_d  = step_sh_q;
        mode_sh_d  = mode_sh_q;
        peak_f_d   = 1'b0;
        valley_f_d = 1'b0;
        if (!cbus.ENABLE) begin
            cnt_d     = '0;
            dir_d     = DIR_UP;
            step_sh_d = cbus.STEP;
            mode_sh_d = mode_e'(cbus.MODE);
        end else if (mode_sh_q == MODE_SAW) begin
            dir_d = DIR_UP;
            if (sum >= LMAX_W) begin
                cnt_d      = LMIN_W[LEVEL_BITS-1:0];
                valley_f_d = 1'b1;
                step_sh_d  = cbus.STEP;
                mode_sh_d  = mode_e'(cbus.MODE);
            end else begin
                cnt_d = sum[LEVEL_BITS-1:0];
            end
        end else if (dir_q == DIR_UP) begin
            if (sum >= LMAX_W) begin
                cnt_d    = LMAX_W[LEVEL_BITS-1:0];
                dir_d    = DIR_DOWN;
                peak_f_d = 1'b1;
            end else begin
                cnt_d = sum[LEVEL_BITS-1:0];
            end
        end else begin
            if (diff <= LMIN_W) begin
                cnt_d      = LMIN_W[LEVEL_BITS-1:0];
                dir_d      = DIR_UP;
                valley_f_d = 1'b1;
                step_sh_d  = cbus.STEP;
                mode_sh_d  = mode_e'(cbus.MODE);
            end else begin
                cnt_d = diff[LEVEL_BITS-1:0];
            end
        end
    end

    always_comb begin
        carrier_d = '0;
        lvl_k     = '0;
        ext_k     = '0;
        if (cbus.ENABLE) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                lvl_k = PHASE_INV[k] ? -cnt_q : cnt_q;
                ext_k = OUTPUT_BITS'(lvl_k);
                carrier_d[k*OUTPUT_BITS +: OUTPUT_BITS] = ext_k <<< (OUTPUT_BITS - LEVEL_BITS);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q      <= '0;
            dir_q      <= DIR_UP;
            step_sh_q  <= (LEVEL_BITS-1)'(1);
            mode_sh_q  <= MODE_TRI;
            peak_f_q   <= 1'b0;
            valley_f_q <= 1'b0;
            carrier_q  <= '0;
            peak_q     <= 1'b0;
            valley_q   <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            step_sh_q  <= step_sh_d;
            mode_sh_q  <= mode_sh_d;
            peak_f_q   <= peak_f_d;
            valley_f_q <= valley_f_d;
            carrier_q  <= carrier_d;
            // Flags ride one stage behind cnt so pulses line up with the extreme on CARRIER;
            // a flag pending when ENABLE drops is swallowed.
            peak_q     <= cbus.ENABLE & peak_f_q;
            valley_q   <= cbus.ENABLE & valley_f_q;
            lock_q     <= cbus.ENABLE & (lock_q | valley_f_q);
        end
    end

    assign cbus.CARRIER = carrier_q;
    assign cbus.PEAK    = peak_q;
    assign cbus.VALLEY  = valley_q;
    // Gated combinationally so LOCK drops the moment ENABLE does.
    assign cbus.LOCK    = lock_q & cbus.ENABLE;

endmodule

// File: tb/tb_ac_motor_carrier_gen.sv
// tb_ac_motor_carrier_gen
//   Self-checking bench for ac_motor_carrier_gen at LEVEL_BITS=4 (LMAX=7),
//   OUTPUT_BITS=8, CHANNELS=3, PHASE_INV=3'b010. An integer level model predicts
//   the carrier; pulses and LOCK are derived from the value expected on CARRIER.
module tb_ac_motor_carrier_gen;

    localparam int unsigned OB   = 8;
    localparam int unsigned LB   = 4;
    localparam int unsigned CH   = 3;
    localparam logic [2:0]  INV  = 3'b010;
    localparam int          LMAX = 7;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // reference model state
    int lvl;
    bit up;
    int sh;
    bit saw;
    bit lock_m;

    ac_motor_carrier_gen_if #(.OUTPUT_BITS(OB), .LEVEL_BITS(LB), .CHANNELS(CH)) bus ();

    ac_motor_carrier_gen #(
        .OUTPUT_BITS(OB),
        .LEVEL_BITS (LB),
        .CHANNELS   (CH),
        .PHASE_INV  (INV)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .cbus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pack(input int l);
        logic [23:0] r;
        int v;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            v = INV[k] ? -l : l;
            v = v * 16;
            r[k*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        lvl    = 0;
        up     = 1'b1;
        sh     = 1;
        saw    = 1'b0;
        lock_m = 1'b0;
    endtask

    // One clock: drive inputs, predict outputs, advance model, sample after the edge.
    task automatic cycle(input bit en, input bit md, input int st);
        int          s;
        logic [23:0] ec;
        bit          ep, ev;
        bus.ENABLE = en;
        bus.MODE   = md;
        bus.STEP   = st[2:0];
        if (en) begin
            ec     = pack(lvl);
            ep     = (lvl == LMAX);
            ev     = (lvl == -LMAX);
            lock_m = lock_m | ev;
        end else begin
            ec     = '0;
            ep     = 1'b0;
            ev     = 1'b0;
            lock_m = 1'b0;
        end
        if (!en) begin
            lvl = 0; up = 1'b1; sh = st; saw = md;
        end else begin
            s = (sh == 0) ? 1 : sh;
            if (saw) begin
                up = 1'b1;
                if (lvl + s >= LMAX) begin lvl = -LMAX; sh = st; saw = md; end
                else lvl = lvl + s;
            end else if (up) begin
                if (lvl + s >= LMAX) begin lvl = LMAX; up = 1'b0; end
                else lvl = lvl + s;
            end else begin
                if (lvl - s <= -LMAX) begin lvl = -LMAX; up = 1'b1; sh = st; saw = md; end
                else lvl = lvl - s;
            end
        end
        @(posedge clk);
        #1;
        check("carrier", 32'(bus.CARRIER), 32'(ec));
        check("peak",    32'(bus.PEAK),    32'(ep));
        check("valley",  32'(bus.VALLEY),  32'(ev));
        check("lock",    32'(bus.LOCK),    32'(lock_m));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        bus.ENABLE = 1'b0;
        bus.MODE   = 1'b0;
        bus.STEP   = 3'd1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_carrier", 32'(bus.CARRIER), 32'h0);
        check("rst_peak",    32'(bus.PEAK),    32'h0);
        check("rst_valley",  32'(bus.VALLEY),  32'h0);
        check("rst_lock",    32'(bus.LOCK),    32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // idle a few clocks, then STEP=1 triangle: full period 0..7..-7 and back
        repeat (3) cycle(1'b0, 1'b0, 1);
        repeat (34) cycle(1'b1, 1'b0, 1);

        // STEP=3 applied from idle
        repeat (2) cycle(1'b0, 1'b0, 3);
        repeat (20) cycle(1'b1, 1'b0, 3);

        // STEP 1 -> 2 while counting up: new slope only after the valley
        repeat (2) cycle(1'b0, 1'b0, 1);
        repeat (3) cycle(1'b1, 1'b0, 1);
        repeat (30) cycle(1'b1, 1'b0, 2);

        // sawtooth STEP=2, then max step 7 and zero step
        repeat (2) cycle(1'b0, 1'b1, 2);
        repeat (20) cycle(1'b1, 1'b1, 2);
        repeat (20) cycle(1'b1, 1'b0, 7);
        repeat (20) cycle(1'b1, 1'b0, 0);

        // randomized run
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));

        // async reset mid-run: outputs clear without a clock
        repeat (12) cycle(1'b1, 1'b0, 2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_carrier", 32'(bus.CARRIER), 32'h0);
        check("arst_peak",    32'(bus.PEAK),    32'h0);
        check("arst_valley",  32'(bus.VALLEY),  32'h0);
        check("arst_lock",    32'(bus.LOCK),    32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // reset left the enabled counter at 0 with step 1; first edge after release already ran
        lvl = 1;
        repeat (30) cycle(1'b1, 1'b1, 3);

        // ENABLE drop mid-run: LOCK falls at once, idle next clock, restart at 0
        repeat (5) cycle(1'b1, 1'b0, 1);
        bus.ENABLE = 1'b0;
        #1;
        check("lock_drop", 32'(bus.LOCK), 32'h0);
        repeat (2) cycle(1'b0, 1'b0, 1);
        repeat (32) cycle(1'b1, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
